// File: rtl/mul_exec_unit_pkg.sv
// Shared definitions for the MUL execution unit and its reservation station.
// Holds the default datapath widths, the multiply opcode enum, the wake bundle
// issued by the RS and the result-bus record used for operand forwarding.
package mul_exec_unit_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned PregW = 5;
  localparam int unsigned RobW  = 5;

  typedef enum logic [1:0] {
    MulW   = 2'b00,  // low 32 bits
    MulhW  = 2'b01,  // signed high 32 bits
    MulhWu = 2'b10   // unsigned high 32 bits
  } mul_op_e;

  typedef struct packed {
    logic [PregW-1:0] pa;
    logic [PregW-1:0] pb;
    logic [PregW-1:0] pw;
    logic [RobW-1:0]  tag_rob;
  } wake_bundle_t;

  typedef struct packed {
    logic             valid;
    logic [PregW-1:0] pw;
    logic [DataW-1:0] data;
  } result_bus_t;

  // The reserved encoding 2'b11 behaves as a low multiply.
  function automatic mul_op_e decode_op(input logic [1:0] op);
    case (op)
      2'b01:   return MulhW;
      2'b10:   return MulhWu;
      default: return MulW;
    endcase
  endfunction

endpackage

// File: rtl/mul_exec_unit_operand_forward.sv
// Combinational operand select for one source operand.
// Ports:
//   preg_i     - source physical register tag
//   rdata_i    - register file read data for preg_i
//   add_bus_i  - ADD result bus (highest priority)
//   ls_bus_i   - LS result bus, valid already qualified by its mode bit
//   mul_bus_i  - this unit's own result bus (lowest forwarding priority)
//   operand_o  - selected operand value
module mul_exec_unit_operand_forward
  import mul_exec_unit_pkg::*;
(
  input  logic [PregW-1:0] preg_i,
  input  logic [DataW-1:0] rdata_i,
  input  result_bus_t      add_bus_i,
  input  result_bus_t      ls_bus_i,
  input  result_bus_t      mul_bus_i,
  output logic [DataW-1:0] operand_o
);

  logic fwd_ok;

  // Tag 0 is the architectural zero register and must always read the PRF.
  assign fwd_ok = (preg_i != '0);

  always_comb begin
    operand_o = rdata_i;
    if (fwd_ok && add_bus_i.valid && (add_bus_i.pw == preg_i)) begin
      operand_o = add_bus_i.data;
    end else if (fwd_ok && ls_bus_i.valid && (ls_bus_i.pw == preg_i)) begin
      operand_o = ls_bus_i.data;
    end else if (fwd_ok && mul_bus_i.valid && (mul_bus_i.pw == preg_i)) begin
      operand_o = mul_bus_i.data;
    end
  end

endmodule

// File: rtl/mul_exec_unit.sv
// MUL execution unit: operand read/forward, then a 3-stage pipelined multiply
// (E1 operand extend, E2 partial products, E3 final sum and select) whose
// result is broadcast on the MUL result bus.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   flush, freeze_back  - kill all in-flight ops / hold every stage
//   *_awake, op_mul     - wake bundle and opcode from the reservation station
//   raddr_*, rdata_*    - PRF read port (combinational)
//   *_Result_add/ls     - forwarding sources
//   *_Result_mul, tag_ROB_mul - MUL result bus and ROB completion tag
module mul_exec_unit
  import mul_exec_unit_pkg::*;
#(
  // Widths must match the package defaults used by the bus structs.
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned PREG_W = PregW,
  parameter int unsigned ROB_W  = RobW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze_back,
  input  logic              valid_op_awake,
  input  logic [PREG_W-1:0] Pa_awake,
  input  logic [PREG_W-1:0] Pb_awake,
  input  logic [PREG_W-1:0] Pw_awake,
  input  logic [ROB_W-1:0]  tag_ROB_awake,
  input  logic [1:0]        op_mul,
  output logic [PREG_W-1:0] raddr_a,
  output logic [PREG_W-1:0] raddr_b,
  input  logic [DATA_W-1:0] rdata_a,
  input  logic [DATA_W-1:0] rdata_b,
  input  logic [PREG_W-1:0] Pw_Result_add,
  input  logic              valid_Result_add,
  input  logic [DATA_W-1:0] Data_Result_add,
  input  logic [PREG_W-1:0] Pw_Result_ls,
  input  logic              valid_Result_ls,
  input  logic              mode_ls,
  input  logic [DATA_W-1:0] Data_Result_ls,
  output logic              valid_Result_mul,
  output logic [PREG_W-1:0] Pw_Result_mul,
  output logic [DATA_W-1:0] Data_Result_mul,
  output logic [ROB_W-1:0]  tag_ROB_mul
);

  localparam int unsigned ExtW  = DATA_W + 1;   // operand with sign/zero extension bit
  localparam int unsigned PpW   = 2 * ExtW;     // partial product / product width
  localparam int unsigned HalfW = DATA_W / 2;   // split point of operand B

  // ---------------------------------------------------------------------------
  // RD: operand select
  // ---------------------------------------------------------------------------
  wake_bundle_t      wake;
  result_bus_t       add_bus, ls_bus, mul_bus;
  logic [DATA_W-1:0] opnd_a, opnd_b;

  assign wake = '{pa: Pa_awake, pb: Pb_awake, pw: Pw_awake, tag_rob: tag_ROB_awake};

  assign raddr_a = wake.pa;
  assign raddr_b = wake.pb;

  assign add_bus = '{valid: valid_Result_add, pw: Pw_Result_add, data: Data_Result_add};
  assign ls_bus  = '{valid: valid_Result_ls & mode_ls, pw: Pw_Result_ls, data: Data_Result_ls};
  assign mul_bus = '{valid: valid_Result_mul, pw: Pw_Result_mul, data: Data_Result_mul};

  mul_exec_unit_operand_forward u_fwd_a (
    .preg_i    (wake.pa),
    .rdata_i   (rdata_a),
    .add_bus_i (add_bus),
    .ls_bus_i  (ls_bus),
    .mul_bus_i (mul_bus),
    .operand_o (opnd_a)
  );

  mul_exec_unit_operand_forward u_fwd_b (
    .preg_i    (wake.pb),
    .rdata_i   (rdata_b),
    .add_bus_i (add_bus),
    .ls_bus_i  (ls_bus),
    .mul_bus_i (mul_bus),
    .operand_o (opnd_b)
  );

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic              e1_valid_q, e1_valid_d;
  logic [ExtW-1:0]   e1_a_q, e1_a_d, e1_b_q, e1_b_d;
  logic [PREG_W-1:0] e1_pw_q, e1_pw_d;
  logic [ROB_W-1:0]  e1_tag_q, e1_tag_d;
  mul_op_e           e1_op_q, e1_op_d;

  logic              e2_valid_q, e2_valid_d;
  logic [PpW-1:0]    e2_pp_lo_q, e2_pp_lo_d, e2_pp_hi_q, e2_pp_hi_d;
  logic [PREG_W-1:0] e2_pw_q, e2_pw_d;
  logic [ROB_W-1:0]  e2_tag_q, e2_tag_d;
  mul_op_e           e2_op_q, e2_op_d;

  logic              out_valid_q, out_valid_d;
  logic [PREG_W-1:0] out_pw_q, out_pw_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ROB_W-1:0]  out_tag_q, out_tag_d;

  // ---------------------------------------------------------------------------
  // E1: extend operands to 33 bits (sign-extend only for signed-high)
  // ---------------------------------------------------------------------------
  mul_op_e op_dec;
  logic    sign_ext;

  assign op_dec   = decode_op(op_mul);
  assign sign_ext = (op_dec == MulhW);

  always_comb begin
    e1_valid_d = valid_op_awake;
    e1_a_d     = '0;
    e1_b_d     = '0;
    e1_pw_d    = '0;
    e1_tag_d   = '0;
    e1_op_d    = MulW;
    if (valid_op_awake) begin
      e1_a_d   = {sign_ext & opnd_a[DATA_W-1], opnd_a};
      e1_b_d   = {sign_ext & opnd_b[DATA_W-1], opnd_b};
      e1_pw_d  = wake.pw;
      e1_tag_d = wake.tag_rob;
      e1_op_d  = op_dec;
    end
  end

  // ---------------------------------------------------------------------------
  // E2: partial products A*B_lo (B_lo unsigned) and A*B_hi (B_hi signed).
  // Operands are extended to the full product width so the modular product
  // equals the signed product.
  // ---------------------------------------------------------------------------
  logic [PpW-1:0] a_ext, b_lo_ext, b_hi_ext;

  assign a_ext    = {{ExtW{e1_a_q[ExtW-1]}}, e1_a_q};
  assign b_lo_ext = {{(PpW - HalfW){1'b0}}, e1_b_q[HalfW-1:0]};
  assign b_hi_ext = {{(PpW - (ExtW - HalfW)){e1_b_q[ExtW-1]}}, e1_b_q[ExtW-1:HalfW]};

  always_comb begin
    e2_valid_d = e1_valid_q;
    e2_pp_lo_d = '0;
    e2_pp_hi_d = '0;
    e2_pw_d    = '0;
    e2_tag_d   = '0;
    e2_op_d    = MulW;
    if (e1_valid_q) begin
      e2_pp_lo_d = a_ext * b_lo_ext;
      e2_pp_hi_d = a_ext * b_hi_ext;
      e2_pw_d    = e1_pw_q;
      e2_tag_d   = e1_tag_q;
      e2_op_d    = e1_op_q;
    end
  end

  // ---------------------------------------------------------------------------
  // E3: recombine and select the low or high word
  // ---------------------------------------------------------------------------
  logic [PpW-1:0] product;

  assign product = (e2_pp_hi_q << HalfW) + e2_pp_lo_q;

  always_comb begin
    out_valid_d = e2_valid_q;
    out_pw_d    = '0;
    out_data_d  = '0;
    out_tag_d   = '0;
    if (e2_valid_q) begin
      out_pw_d   = e2_pw_q;
      out_tag_d  = e2_tag_q;
      out_data_d = (e2_op_q == MulW) ? product[DATA_W-1:0] : product[2*DATA_W-1:DATA_W];
    end
  end

  // Flush beats freeze; freeze holds every register including the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e1_valid_q  <= 1'b0;
      e1_a_q      <= '0;
      e1_b_q      <= '0;
      e1_pw_q     <= '0;
      e1_tag_q    <= '0;
      e1_op_q     <= MulW;
      e2_valid_q  <= 1'b0;
      e2_pp_lo_q  <= '0;
      e2_pp_hi_q  <= '0;
      e2_pw_q     <= '0;
      e2_tag_q    <= '0;
      e2_op_q     <= MulW;
      out_valid_q <= 1'b0;
      out_pw_q    <= '0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (flush) begin
      e1_valid_q  <= 1'b0;
      e1_a_q      <= '0;
      e1_b_q      <= '0;
      e1_pw_q     <= '0;
      e1_tag_q    <= '0;
      e1_op_q     <= MulW;
      e2_valid_q  <= 1'b0;
      e2_pp_lo_q  <= '0;
      e2_pp_hi_q  <= '0;
      e2_pw_q     <= '0;
      e2_tag_q    <= '0;
      e2_op_q     <= MulW;
      out_valid_q <= 1'b0;
      out_pw_q    <= '0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (!freeze_back) begin
      e1_valid_q  <= e1_valid_d;
      e1_a_q      <= e1_a_d;
      e1_b_q      <= e1_b_d;
      e1_pw_q     <= e1_pw_d;
      e1_tag_q    <= e1_tag_d;
      e1_op_q     <= e1_op_d;
      e2_valid_q  <= e2_valid_d;
      e2_pp_lo_q  <= e2_pp_lo_d;
      e2_pp_hi_q  <= e2_pp_hi_d;
      e2_pw_q     <= e2_pw_d;
      e2_tag_q    <= e2_tag_d;
      e2_op_q     <= e2_op_d;
      out_valid_q <= out_valid_d;
      out_pw_q    <= out_pw_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign valid_Result_mul = out_valid_q;
  assign Pw_Result_mul    = out_pw_q;
  assign Data_Result_mul  = out_data_q;
  assign tag_ROB_mul      = out_tag_q;

endmodule

// File: tb/tb_mul_exec_unit.sv
// Self-checking bench for mul_exec_unit: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_mul_exec_unit;

  logic        clk, rst, flush, freeze_back, valid_op_awake;
  logic [4:0]  Pa_awake, Pb_awake, Pw_awake, tag_ROB_awake;
  logic [1:0]  op_mul;
  logic [4:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a, rdata_b;
  logic [4:0]  Pw_Result_add, Pw_Result_ls;
  logic        valid_Result_add, valid_Result_ls, mode_ls;
  logic [31:0] Data_Result_add, Data_Result_ls;
  logic        valid_Result_mul;
  logic [4:0]  Pw_Result_mul, tag_ROB_mul;
  logic [31:0] Data_Result_mul;

  mul_exec_unit dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .freeze_back      (freeze_back),
    .valid_op_awake   (valid_op_awake),
    .Pa_awake         (Pa_awake),
    .Pb_awake         (Pb_awake),
    .Pw_awake         (Pw_awake),
    .tag_ROB_awake    (tag_ROB_awake),
    .op_mul           (op_mul),
    .raddr_a          (raddr_a),
    .raddr_b          (raddr_b),
    .rdata_a          (rdata_a),
    .rdata_b          (rdata_b),
    .Pw_Result_add    (Pw_Result_add),
    .valid_Result_add (valid_Result_add),
    .Data_Result_add  (Data_Result_add),
    .Pw_Result_ls     (Pw_Result_ls),
    .valid_Result_ls  (valid_Result_ls),
    .mode_ls          (mode_ls),
    .Data_Result_ls   (Data_Result_ls),
    .valid_Result_mul (valid_Result_mul),
    .Pw_Result_mul    (Pw_Result_mul),
    .Data_Result_mul  (Data_Result_mul),
    .tag_ROB_mul      (tag_ROB_mul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of ops in flight, each with the number of
  // non-frozen edges it has seen; after three it becomes the visible result.
  typedef struct {
    logic [4:0]  pw;
    logic [4:0]  tag;
    logic [31:0] data;
    int          age;
  } item_t;

  item_t       pend[$];
  logic        m_valid;
  logic [4:0]  m_pw, m_tag;
  logic [31:0] m_data;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    longint      sp;
    logic [63:0] up;
    up = {32'd0, a} * {32'd0, b};
    sp = longint'($signed(a)) * longint'($signed(b));
    case (op)
      2'b01:   return sp[63:32];
      2'b10:   return up[63:32];
      default: return up[31:0];
    endcase
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] p, input logic [31:0] rd);
    if (p == 5'd0) return rd;
    if (valid_Result_add && Pw_Result_add == p) return Data_Result_add;
    if (valid_Result_ls && mode_ls && Pw_Result_ls == p) return Data_Result_ls;
    if (m_valid && m_pw == p) return m_data;
    return rd;
  endfunction

  task automatic model_clear();
    pend.delete();
    m_valid = 1'b0;
    m_pw    = '0;
    m_tag   = '0;
    m_data  = '0;
  endtask

  task automatic model_step();
    item_t it;
    if (flush) begin
      model_clear();
      return;
    end
    if (freeze_back) return;
    if (valid_op_awake) begin
      it.pw   = Pw_awake;
      it.tag  = tag_ROB_awake;
      it.data = ref_mul(ref_operand(Pa_awake, rdata_a), ref_operand(Pb_awake, rdata_b), op_mul);
      it.age  = 0;
      pend.push_back(it);
    end
    foreach (pend[i]) pend[i].age++;
    if (pend.size() > 0 && pend[0].age == 3) begin
      m_valid = 1'b1;
      m_pw    = pend[0].pw;
      m_tag   = pend[0].tag;
      m_data  = pend[0].data;
      void'(pend.pop_front());
    end else begin
      m_valid = 1'b0;
      m_pw    = '0;
      m_tag   = '0;
      m_data  = '0;
    end
  endtask

  task automatic idle();
    flush            = 1'b0;
    freeze_back      = 1'b0;
    valid_op_awake   = 1'b0;
    Pa_awake         = '0;
    Pb_awake         = '0;
    Pw_awake         = '0;
    tag_ROB_awake    = '0;
    op_mul           = '0;
    rdata_a          = '0;
    rdata_b          = '0;
    Pw_Result_add    = '0;
    valid_Result_add = 1'b0;
    Data_Result_add  = '0;
    Pw_Result_ls     = '0;
    valid_Result_ls  = 1'b0;
    mode_ls          = 1'b0;
    Data_Result_ls   = '0;
  endtask

  // Called at a falling edge with inputs set: advance model, cross the rising
  // edge, then compare at the next falling edge.
  task automatic tick();
    check_eq("raddr_a", {59'd0, raddr_a}, {59'd0, Pa_awake});
    check_eq("raddr_b", {59'd0, raddr_b}, {59'd0, Pb_awake});
    model_step();
    @(negedge clk);
    check_eq("valid", {63'd0, valid_Result_mul}, {63'd0, m_valid});
    check_eq("pw", {59'd0, Pw_Result_mul}, {59'd0, m_pw});
    check_eq("data", {32'd0, Data_Result_mul}, {32'd0, m_data});
    check_eq("tag", {59'd0, tag_ROB_mul}, {59'd0, m_tag});
  endtask

  task automatic wake(input logic [4:0] pa, input logic [4:0] pb, input logic [4:0] pw,
                      input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    valid_op_awake = 1'b1;
    Pa_awake       = pa;
    Pb_awake       = pb;
    Pw_awake       = pw;
    tag_ROB_awake  = 5'd3;
    op_mul         = op;
    rdata_a        = a;
    rdata_b        = b;
  endtask

  // One isolated op (forwarding buses set by the caller beforehand).
  task automatic single_op(input logic [4:0] pa, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, output logic [31:0] res);
    wake(pa, 5'd6, 5'd9, a, b, op);
    tick();
    idle();
    tick();
    tick();
    res = Data_Result_mul;
    tick();
  endtask

  logic [31:0] res;

  initial begin
    idle();
    model_clear();
    rst = 1'b1;
    #1;
    check_eq("reset_valid", {63'd0, valid_Result_mul}, 64'd0);
    check_eq("reset_data", {32'd0, Data_Result_mul}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic low multiply with explicit latency checks.
    wake(5'd1, 5'd2, 5'd9, 32'd7, 32'd6, 2'b00);
    tick();
    check_eq("basic_t1_valid", {63'd0, valid_Result_mul}, 64'd0);
    idle();
    tick();
    check_eq("basic_t2_valid", {63'd0, valid_Result_mul}, 64'd0);
    tick();
    check_eq("basic_valid", {63'd0, valid_Result_mul}, 64'd1);
    check_eq("basic_pw", {59'd0, Pw_Result_mul}, 64'd9);
    check_eq("basic_data", {32'd0, Data_Result_mul}, 64'd42);
    check_eq("basic_tag", {59'd0, tag_ROB_mul}, 64'd3);
    tick();
    check_eq("basic_t4_valid", {63'd0, valid_Result_mul}, 64'd0);
    check_eq("basic_t4_data", {32'd0, Data_Result_mul}, 64'd0);

    // High products.
    single_op(5'd1, 32'hFFFF_FFFF, 32'd2, 2'b01, res);
    check_eq("mulh_signed", {32'd0, res}, 64'hFFFF_FFFF);
    single_op(5'd1, 32'hFFFF_FFFF, 32'd2, 2'b10, res);
    check_eq("mulh_unsigned", {32'd0, res}, 64'h1);
    single_op(5'd1, 32'hFFFF_FFFF, 32'd2, 2'b00, res);
    check_eq("mul_low", {32'd0, res}, 64'hFFFF_FFFE);
    single_op(5'd1, 32'hFFFF_FFFF, 32'd2, 2'b11, res);
    check_eq("mul_reserved", {32'd0, res}, 64'hFFFF_FFFE);

    // Forwarding priority.
    idle();
    valid_Result_add = 1'b1; Pw_Result_add = 5'd5; Data_Result_add = 32'd3;
    valid_Result_ls = 1'b1; Pw_Result_ls = 5'd5; Data_Result_ls = 32'd8; mode_ls = 1'b1;
    single_op(5'd5, 32'd100, 32'd10, 2'b00, res);
    check_eq("fwd_add", {32'd0, res}, 64'd30);
    idle();
    Pw_Result_add = 5'd5; Data_Result_add = 32'd3;
    valid_Result_ls = 1'b1; Pw_Result_ls = 5'd5; Data_Result_ls = 32'd8; mode_ls = 1'b1;
    single_op(5'd5, 32'd100, 32'd10, 2'b00, res);
    check_eq("fwd_ls", {32'd0, res}, 64'd80);
    idle();
    Pw_Result_add = 5'd5; Data_Result_add = 32'd3;
    valid_Result_ls = 1'b1; Pw_Result_ls = 5'd5; Data_Result_ls = 32'd8;
    single_op(5'd5, 32'd100, 32'd10, 2'b00, res);
    check_eq("fwd_ls_mode0", {32'd0, res}, 64'd1000);
    idle();
    valid_Result_add = 1'b1; Pw_Result_add = 5'd0; Data_Result_add = 32'd3;
    single_op(5'd0, 32'd100, 32'd10, 2'b00, res);
    check_eq("fwd_tag0", {32'd0, res}, 64'd1000);

    // Back-to-back with freeze.
    idle();
    wake(5'd1, 5'd2, 5'd10, 32'd2, 32'd2, 2'b00); tick();
    wake(5'd1, 5'd2, 5'd11, 32'd3, 32'd3, 2'b00); tick();
    wake(5'd1, 5'd2, 5'd12, 32'd4, 32'd4, 2'b00); tick();
    check_eq("b2b_t3", {32'd0, Data_Result_mul}, 64'd4);
    idle();
    freeze_back = 1'b1;
    tick();
    check_eq("freeze_t4", {32'd0, Data_Result_mul}, 64'd4);
    check_eq("freeze_t4_valid", {63'd0, valid_Result_mul}, 64'd1);
    tick();
    check_eq("freeze_t5", {32'd0, Data_Result_mul}, 64'd4);
    freeze_back = 1'b0;
    tick();
    check_eq("b2b_t6", {32'd0, Data_Result_mul}, 64'd9);
    tick();
    check_eq("b2b_t7", {32'd0, Data_Result_mul}, 64'd16);
    tick();
    check_eq("b2b_t8_valid", {63'd0, valid_Result_mul}, 64'd0);

    // Flush.
    wake(5'd1, 5'd2, 5'd9, 32'd2, 32'd3, 2'b00); tick();
    wake(5'd1, 5'd2, 5'd9, 32'd4, 32'd5, 2'b00); tick();
    idle();
    flush = 1'b1;
    tick();
    check_eq("flush_t3", {63'd0, valid_Result_mul}, 64'd0);
    flush = 1'b0;
    wake(5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 2'b00); tick();
    check_eq("flush_t4", {63'd0, valid_Result_mul}, 64'd0);
    idle();
    tick();
    check_eq("flush_t5", {63'd0, valid_Result_mul}, 64'd0);
    tick();
    check_eq("flush_t6_valid", {63'd0, valid_Result_mul}, 64'd1);
    check_eq("flush_t6_data", {32'd0, Data_Result_mul}, 64'd35);
    tick();

    // Async reset with three ops in flight.
    wake(5'd1, 5'd2, 5'd9, 32'd6, 32'd6, 2'b00); tick();
    wake(5'd1, 5'd2, 5'd9, 32'd7, 32'd7, 2'b00); tick();
    wake(5'd1, 5'd2, 5'd9, 32'd8, 32'd8, 2'b00); tick();
    idle();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", {63'd0, valid_Result_mul}, 64'd0);
    check_eq("arst_pw", {59'd0, Pw_Result_mul}, 64'd0);
    check_eq("arst_data", {32'd0, Data_Result_mul}, 64'd0);
    check_eq("arst_tag", {59'd0, tag_ROB_mul}, 64'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      flush            = ($urandom_range(0, 15) == 0);
      freeze_back      = ($urandom_range(0, 5) == 0);
      valid_op_awake   = ($urandom_range(0, 3) != 0);
      Pa_awake         = 5'($urandom_range(0, 3));
      Pb_awake         = 5'($urandom_range(0, 3));
      Pw_awake         = 5'($urandom_range(0, 3));
      tag_ROB_awake    = 5'($urandom_range(0, 31));
      op_mul           = 2'($urandom_range(0, 3));
      rdata_a          = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rdata_b          = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 5))
                                                      : $urandom;
      valid_Result_add = 1'($urandom_range(0, 1));
      Pw_Result_add    = 5'($urandom_range(0, 3));
      Data_Result_add  = $urandom;
      valid_Result_ls  = 1'($urandom_range(0, 1));
      mode_ls          = 1'($urandom_range(0, 1));
      Pw_Result_ls     = 5'($urandom_range(0, 3));
      Data_Result_ls   = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
